// File: rtl/benes_ctrl_loader.sv
// Control-bit loader for a SIZE-port Benes network.
//
// Holds a shadow bank and an active bank of per-switch cross/bar bits.
// A host streams one control word per stage into the shadow bank. Once a
// complete set has been loaded, a commit request copies shadow into active
// in one step, but only while the network reports that it is drained.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cfg_valid   : control word valid
//   cfg_ready   : loader accepts a word this cycle (LOAD state only)
//   cfg_stage   : target stage index of the word
//   cfg_bits    : per-switch bits, 1 = cross, 0 = bar
//   cfg_last    : final word of the set
//   commit_req  : level request to activate the loaded set
//   net_idle    : network pipeline empty
//   commit_ack  : one-cycle pulse, visible together with the new sw_ctrl
//   sw_ctrl     : active bank, bits [s*SWITCH_NUM +: SWITCH_NUM] drive stage s
//   cfg_err     : sticky set-level error, cleared by a commit or reset
//   cfg_epoch   : count of completed commits (wraps)
module benes_ctrl_loader #(
  parameter int SIZE       = 32,
  parameter int SWITCH_NUM = SIZE / 2,
  parameter int STAGE_NUM  = 2 * $clog2(SIZE) - 1,
  parameter int STG_W      = $clog2(STAGE_NUM),
  parameter int EPOCH_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [STG_W-1:0]                cfg_stage,
  input  logic [SWITCH_NUM-1:0]           cfg_bits,
  input  logic                            cfg_last,
  input  logic                            commit_req,
  input  logic                            net_idle,
  output logic                            commit_ack,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] sw_ctrl,
  output logic                            cfg_err,
  output logic [EPOCH_W-1:0]              cfg_epoch
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ARMED = 2'd1,
    SWAP  = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [STAGE_NUM*SWITCH_NUM-1:0]   shadow_q, shadow_d;
  logic [STAGE_NUM*SWITCH_NUM-1:0]   active_q, active_d;
  logic [STAGE_NUM-1:0]              mask_q, mask_d;
  logic [STAGE_NUM-1:0]              mask_upd;
  logic                              ack_q, ack_d;
  logic                              err_q, err_d;
  logic [EPOCH_W-1:0]                epoch_q, epoch_d;
  logic                              stage_ok;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    mask_d    = mask_q;
    mask_upd  = mask_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    epoch_d   = epoch_q;
    cfg_ready = 1'b0;
    stage_ok  = 32'(cfg_stage) < STAGE_NUM;

    case (state_q)
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (stage_ok) begin
            for (int unsigned s = 0; s < STAGE_NUM; s++) begin
              if (32'(cfg_stage) == s) begin
                shadow_d[s*SWITCH_NUM +: SWITCH_NUM] = cfg_bits;
                mask_upd[s] = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
          mask_d = mask_upd;
          // The completeness test includes the word accepted this cycle.
          if (cfg_last) begin
            if (&mask_upd) begin
              state_d = ARMED;
            end else begin
              err_d  = 1'b1;
              mask_d = '0;
            end
          end
        end
      end

      ARMED: begin
        if (commit_req && net_idle) begin
          state_d = SWAP;
        end
      end

      SWAP: begin
        active_d = shadow_q;
        mask_d   = '0;
        epoch_d  = epoch_q + EPOCH_W'(1);
        err_d    = 1'b0;
        ack_d    = 1'b1;
        state_d  = LOAD;
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      shadow_q <= '0;
      active_q <= '0;
      mask_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      epoch_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      mask_q   <= mask_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      epoch_q  <= epoch_d;
    end
  end

  assign sw_ctrl    = active_q;
  assign commit_ack = ack_q;
  assign cfg_err    = err_q;
  assign cfg_epoch  = epoch_q;

endmodule
